wave_controller: RTL and testbench

WAVE_CONTROLLER -- requirements
Module: wave_controller

---
 rtl/wave_controller.sv | 212 +++++++++++++++++++++
 tb/tb_wave_controller.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_controller.sv
// Game-flow controller for the wave shooter: title, enemy waves, respawn, boss fight and end screens.
// Tracks score, lives, wave index and boss health; every output comes straight from a register.
module wave_controller #(
  parameter int          NUM_ROWS       = 3,
  parameter int          SHIPS_PER_ROW  = 6,
  parameter int          NUM_WAVES      = 2,
  parameter int          LIVES          = 3,
  parameter int          BOSS_HP        = 4,
  parameter int          SCORE_W        = 8,
  parameter int          RESPAWN_FRAMES = 60,
  parameter logic [7:0]  START_KEY      = 8'h28,
  localparam int         WAVE_W         = (NUM_WAVES > 1) ? $clog2(NUM_WAVES) : 1,
  localparam int         LIVES_W        = $clog2(LIVES + 1),
  localparam int         HP_W           = $clog2(BOSS_HP + 1)
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_tick,
  input  logic [7:0]          keycode,
  input  logic [NUM_ROWS-1:0] row_kill,
  input  logic                boss_hit,
  input  logic                player_hit,
  output logic                start,
  output logic                play,
  output logic                respawn,
  output logic                boss_logo,
  output logic                boss_fight,
  output logic                gameover,
  output logic                win,
  output logic                done,
  output logic                wave_load,
  output logic [WAVE_W-1:0]   wave,
  output logic [LIVES_W-1:0]  lives,
  output logic [SCORE_W-1:0]  score,
  output logic [HP_W-1:0]     boss_hp
);

  localparam int WAVE_KILLS = NUM_ROWS * SHIPS_PER_ROW;
  localparam int KILL_W     = $clog2(WAVE_KILLS + 1);
  localparam int RESP_W     = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
  localparam int PC_W       = $clog2(NUM_ROWS + 1);

  typedef enum logic [2:0] {
    S_START, S_PLAY, S_RESPAWN, S_BOSS_LOGO, S_BOSS_FIGHT, S_GAMEOVER, S_WIN
  } state_t;

  state_t              state_q, state_d;
  logic [6:0]          flags_q, flags_d;
  logic                done_q, done_d;
  logic                waveLoad_q, waveLoad_d;
  logic [WAVE_W-1:0]   wave_q, wave_d;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [HP_W-1:0]     bossHp_q, bossHp_d;
  logic [KILL_W-1:0]   kills_q, kills_d;
  logic [RESP_W-1:0]   respCnt_q, respCnt_d;
  logic                keyPrev_q, keyPrev_d;
  logic                armed_q, armed_d;

  logic                keyDown, keyEdge;
  logic [PC_W-1:0]     killCount;
  int                  killTotal;
  logic [KILL_W-1:0]   killSat;
  logic [LIVES_W-1:0]  livesDec;
  logic [HP_W-1:0]     hpAfter;

  function automatic logic [SCORE_W-1:0] satAdd(input logic [SCORE_W-1:0] a,
                                                 input logic [PC_W-1:0]    b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + (SCORE_W + 1)'(b);
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

  // The key must be seen released once after reset before a press counts, so a key held through reset is ignored.
  always_comb begin
    keyDown   = (keycode == START_KEY);
    keyEdge   = keyDown && !keyPrev_q && armed_q;
    killCount = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      killCount = killCount + PC_W'(row_kill[r]);
    end
    killTotal = int'(kills_q) + int'(killCount);
    killSat   = (killTotal >= WAVE_KILLS) ? KILL_W'(WAVE_KILLS) : KILL_W'(killTotal);
    livesDec  = (lives_q != '0) ? lives_q - LIVES_W'(1) : '0;
    hpAfter   = bossHp_q;

    state_d    = state_q;
    waveLoad_d = 1'b0;
    wave_d     = wave_q;
    lives_d    = lives_q;
    score_d    = score_q;
    bossHp_d   = bossHp_q;
    kills_d    = kills_q;
    respCnt_d  = respCnt_q;
    keyPrev_d  = keyDown;
    armed_d    = armed_q | ~keyDown;

    case (state_q)
      S_START: begin
        if (keyEdge) begin
          state_d    = S_PLAY;
          wave_d     = '0;
          score_d    = '0;
          lives_d    = LIVES_W'(LIVES);
          kills_d    = '0;
          waveLoad_d = 1'b1;
        end
      end
      // Kills score before a same-cycle hit is judged; losing the last life overrides wave completion.
      S_PLAY: begin
        score_d = satAdd(score_q, killCount);
        kills_d = killSat;
        if (player_hit) begin
          lives_d = livesDec;
          if (livesDec == '0) begin
            state_d = S_GAMEOVER;
          end else begin
            state_d   = S_RESPAWN;
            respCnt_d = '0;
          end
        end else if (killSat == KILL_W'(WAVE_KILLS)) begin
          if (int'(wave_q) < NUM_WAVES - 1) begin
            wave_d     = wave_q + WAVE_W'(1);
            kills_d    = '0;
            waveLoad_d = 1'b1;
          end else begin
            state_d = S_BOSS_LOGO;
          end
        end
      end
      S_RESPAWN: begin
        if (frame_tick) begin
          if (int'(respCnt_q) >= RESPAWN_FRAMES - 1) begin
            state_d   = S_PLAY;
            respCnt_d = '0;
          end else begin
            respCnt_d = respCnt_q + RESP_W'(1);
          end
        end
      end
      S_BOSS_LOGO: begin
        if (keyEdge) begin
          bossHp_d = HP_W'(BOSS_HP);
          state_d  = S_BOSS_FIGHT;
        end
      end
      S_BOSS_FIGHT: begin
        if (boss_hit && bossHp_q != '0) begin
          hpAfter = bossHp_q - HP_W'(1);
          score_d = satAdd(score_q, PC_W'(1));
        end
        bossHp_d = hpAfter;
        if (player_hit) begin
          lives_d = livesDec;
        end
        if (player_hit && livesDec == '0) begin
          state_d = S_GAMEOVER;
        end else if (hpAfter == '0) begin
          state_d = S_WIN;
        end
      end
      S_GAMEOVER, S_WIN: begin
        if (keyEdge) begin
          state_d = S_START;
        end
      end
      default: state_d = S_START;
    endcase

    flags_d = 7'b1 << state_d;
    done_d  = (state_d == S_GAMEOVER) || (state_d == S_WIN);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= S_START;
      flags_q    <= 7'b0000001;
      done_q     <= 1'b0;
      waveLoad_q <= 1'b0;
      wave_q     <= '0;
      lives_q    <= LIVES_W'(LIVES);
      score_q    <= '0;
      bossHp_q   <= '0;
      kills_q    <= '0;
      respCnt_q  <= '0;
      keyPrev_q  <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      done_q     <= done_d;
      waveLoad_q <= waveLoad_d;
      wave_q     <= wave_d;
      lives_q    <= lives_d;
      score_q    <= score_d;
      bossHp_q   <= bossHp_d;
      kills_q    <= kills_d;
      respCnt_q  <= respCnt_d;
      keyPrev_q  <= keyPrev_d;
      armed_q    <= armed_d;
    end
  end

  assign {win, gameover, boss_fight, boss_logo, respawn, play, start} = flags_q;
  assign done      = done_q;
  assign wave_load = waveLoad_q;
  assign wave      = wave_q;
  assign lives     = lives_q;
  assign score     = score_q;
  assign boss_hp   = bossHp_q;

endmodule

// File: tb/tb_wave_controller.sv
// Directed bench for wave_controller: a default instance plus a 4-bit-score instance share one stimulus stream.
// Expected values are queued as each step is driven and drained against the outputs at the following negedge.
module tb_wave_controller;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_tick;
  logic [7:0] keycode;
  logic [2:0] row_kill;
  logic       boss_hit;
  logic       player_hit;

  logic startA, playA, respawnA, bossLogoA, bossFightA, gameoverA, winA, doneA, waveLoadA;
  logic [0:0] waveA;
  logic [1:0] livesA;
  logic [7:0] scoreA;
  logic [2:0] bossHpA;

  logic startB, playB, respawnB, bossLogoB, bossFightB, gameoverB, winB, doneB, waveLoadB;
  logic [0:0] waveB;
  logic [1:0] livesB;
  logic [3:0] scoreB;
  logic [2:0] bossHpB;

  wave_controller dutA (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
    .row_kill(row_kill), .boss_hit(boss_hit), .player_hit(player_hit),
    .start(startA), .play(playA), .respawn(respawnA), .boss_logo(bossLogoA),
    .boss_fight(bossFightA), .gameover(gameoverA), .win(winA), .done(doneA),
    .wave_load(waveLoadA), .wave(waveA), .lives(livesA), .score(scoreA), .boss_hp(bossHpA)
  );

  wave_controller #(.SCORE_W(4)) dutB (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
    .row_kill(row_kill), .boss_hit(boss_hit), .player_hit(player_hit),
    .start(startB), .play(playB), .respawn(respawnB), .boss_logo(bossLogoB),
    .boss_fight(bossFightB), .gameover(gameoverB), .win(winB), .done(doneB),
    .wave_load(waveLoadB), .wave(waveB), .lives(livesB), .score(scoreB), .boss_hp(bossHpB)
  );

  always #5 Clk = ~Clk;

  localparam int SEL_START = 0, SEL_PLAY = 1, SEL_RESPAWN = 2, SEL_LOGO = 3, SEL_FIGHT = 4,
                 SEL_GAMEOVER = 5, SEL_WIN = 6, SEL_DONE = 7, SEL_WLOAD = 8, SEL_WAVE = 9,
                 SEL_LIVES = 10, SEL_SCORE = 11, SEL_HP = 12, SEL_WLCNT = 13;

  typedef struct {
    string tag;
    int    dut;
    int    sel;
    int    exp;
  } exp_t;

  exp_t sbq[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   wlCountA   = 0;
  int   wlBase;

  // wave_load pulses are tallied just after each rising edge so a single pulse is counted once.
  always @(posedge Clk) begin
    #1;
    if (waveLoadA === 1'b1) wlCountA = wlCountA + 1;
  end

  function automatic int observe(input int dut, input int sel);
    if (dut == 0) begin
      case (sel)
        SEL_START:    return int'(startA);
        SEL_PLAY:     return int'(playA);
        SEL_RESPAWN:  return int'(respawnA);
        SEL_LOGO:     return int'(bossLogoA);
        SEL_FIGHT:    return int'(bossFightA);
        SEL_GAMEOVER: return int'(gameoverA);
        SEL_WIN:      return int'(winA);
        SEL_DONE:     return int'(doneA);
        SEL_WLOAD:    return int'(waveLoadA);
        SEL_WAVE:     return int'(waveA);
        SEL_LIVES:    return int'(livesA);
        SEL_SCORE:    return int'(scoreA);
        SEL_HP:       return int'(bossHpA);
        default:      return wlCountA;
      endcase
    end else begin
      case (sel)
        SEL_START:    return int'(startB);
        SEL_PLAY:     return int'(playB);
        SEL_RESPAWN:  return int'(respawnB);
        SEL_LOGO:     return int'(bossLogoB);
        SEL_FIGHT:    return int'(bossFightB);
        SEL_GAMEOVER: return int'(gameoverB);
        SEL_WIN:      return int'(winB);
        SEL_DONE:     return int'(doneB);
        SEL_WLOAD:    return int'(waveLoadB);
        SEL_WAVE:     return int'(waveB);
        SEL_LIVES:    return int'(livesB);
        SEL_SCORE:    return int'(scoreB);
        default:      return int'(bossHpB);
      endcase
    end
  endfunction

  task automatic applyStimulus(input logic rst, input logic [7:0] kc, input logic [2:0] rk,
                               input logic bh, input logic ph, input logic ft, input int cycles);
    Reset      = rst;
    keycode    = kc;
    row_kill   = rk;
    boss_hit   = bh;
    player_hit = ph;
    frame_tick = ft;
    repeat (cycles) @(negedge Clk);
  endtask

  task automatic idle(input int cycles);
    applyStimulus(1'b1, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, cycles);
  endtask

  task automatic keyPress();
    applyStimulus(1'b1, 8'h28, 3'b000, 1'b0, 1'b0, 1'b0, 1);
    idle(1);
  endtask

  task automatic respawnTicks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1, 1);
      idle(1);
    end
  endtask

  task automatic expectVal(input string tag, input int dut, input int sel, input int exp);
    sbq.push_back('{tag, dut, sel, exp});
  endtask

  task automatic expectReset(input string tag, input int dut);
    expectVal({tag, ".start"}, dut, SEL_START, 1);
    expectVal({tag, ".play"}, dut, SEL_PLAY, 0);
    expectVal({tag, ".respawn"}, dut, SEL_RESPAWN, 0);
    expectVal({tag, ".boss_logo"}, dut, SEL_LOGO, 0);
    expectVal({tag, ".boss_fight"}, dut, SEL_FIGHT, 0);
    expectVal({tag, ".gameover"}, dut, SEL_GAMEOVER, 0);
    expectVal({tag, ".win"}, dut, SEL_WIN, 0);
    expectVal({tag, ".done"}, dut, SEL_DONE, 0);
    expectVal({tag, ".wave_load"}, dut, SEL_WLOAD, 0);
    expectVal({tag, ".wave"}, dut, SEL_WAVE, 0);
    expectVal({tag, ".score"}, dut, SEL_SCORE, 0);
    expectVal({tag, ".lives"}, dut, SEL_LIVES, 3);
    expectVal({tag, ".boss_hp"}, dut, SEL_HP, 0);
  endtask

  task automatic checkOutput();
    exp_t e;
    int   obs;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = observe(e.dut, e.sel);
      compared++;
      assert (obs === e.exp) else begin
        mismatched++;
        $error("[TB] FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state on both instances.
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 3);
    expectReset("rst0A", 0);
    expectReset("rst0B", 1);
    checkOutput();

    // A key held through reset release must not start the game.
    wlBase = wlCountA;
    applyStimulus(1'b0, 8'h28, 3'b000, 1'b0, 1'b0, 1'b0, 2);
    applyStimulus(1'b1, 8'h28, 3'b000, 1'b0, 1'b0, 1'b0, 5);
    expectVal("heldKey.start", 0, SEL_START, 1);
    expectVal("heldKey.wlcnt", 0, SEL_WLCNT, wlBase);
    checkOutput();

    // Fresh press held 10 cycles: exactly one start transition.
    idle(1);
    wlBase = wlCountA;
    applyStimulus(1'b1, 8'h28, 3'b000, 1'b0, 1'b0, 1'b0, 10);
    expectVal("startGame.play", 0, SEL_PLAY, 1);
    expectVal("startGame.start", 0, SEL_START, 0);
    expectVal("startGame.lives", 0, SEL_LIVES, 3);
    expectVal("startGame.score", 0, SEL_SCORE, 0);
    expectVal("startGame.wave", 0, SEL_WAVE, 0);
    expectVal("startGame.wlcnt", 0, SEL_WLCNT, wlBase + 1);
    checkOutput();
    idle(1);

    // First wave cleared with all rows firing together.
    wlBase = wlCountA;
    applyStimulus(1'b1, 8'h00, 3'b111, 1'b0, 1'b0, 1'b0, 6);
    idle(1);
    expectVal("wave0.score", 0, SEL_SCORE, 18);
    expectVal("wave0.wave", 0, SEL_WAVE, 1);
    expectVal("wave0.play", 0, SEL_PLAY, 1);
    expectVal("wave0.wlcnt", 0, SEL_WLCNT, wlBase + 1);
    expectVal("wave0.scoreB", 1, SEL_SCORE, 15);
    checkOutput();

    // Player hit, then inputs ignored during respawn, then return after 60 frames.
    applyStimulus(1'b1, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 1);
    idle(1);
    expectVal("hit.lives", 0, SEL_LIVES, 2);
    expectVal("hit.respawn", 0, SEL_RESPAWN, 1);
    expectVal("hit.play", 0, SEL_PLAY, 0);
    checkOutput();
    wlBase = wlCountA;
    applyStimulus(1'b1, 8'h00, 3'b111, 1'b1, 1'b1, 1'b0, 2);
    idle(1);
    expectVal("respIgnore.score", 0, SEL_SCORE, 18);
    expectVal("respIgnore.lives", 0, SEL_LIVES, 2);
    expectVal("respIgnore.respawn", 0, SEL_RESPAWN, 1);
    checkOutput();
    respawnTicks(59);
    expectVal("resp59.respawn", 0, SEL_RESPAWN, 1);
    checkOutput();
    respawnTicks(1);
    expectVal("resp60.play", 0, SEL_PLAY, 1);
    expectVal("resp60.respawn", 0, SEL_RESPAWN, 0);
    expectVal("resp60.wlcnt", 0, SEL_WLCNT, wlBase);
    expectVal("resp60.wave", 0, SEL_WAVE, 1);
    checkOutput();

    // Last wave cleared leads to the boss logo.
    wlBase = wlCountA;
    applyStimulus(1'b1, 8'h00, 3'b111, 1'b0, 1'b0, 1'b0, 6);
    idle(1);
    expectVal("wave1.logo", 0, SEL_LOGO, 1);
    expectVal("wave1.play", 0, SEL_PLAY, 0);
    expectVal("wave1.score", 0, SEL_SCORE, 36);
    expectVal("wave1.wlcnt", 0, SEL_WLCNT, wlBase);
    checkOutput();

    // Boss hits before the fight are ignored; key starts the fight.
    applyStimulus(1'b1, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 1);
    idle(1);
    expectVal("logoIgnore.score", 0, SEL_SCORE, 36);
    expectVal("logoIgnore.hp", 0, SEL_HP, 0);
    checkOutput();
    keyPress();
    expectVal("fight.fight", 0, SEL_FIGHT, 1);
    expectVal("fight.hp", 0, SEL_HP, 4);
    expectVal("fight.logo", 0, SEL_LOGO, 0);
    checkOutput();

    // Four boss hits win; a row kill during the fight must not score.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'h00, (i == 0) ? 3'b111 : 3'b000, 1'b1, 1'b0, 1'b0, 1);
      idle(1);
    end
    expectVal("win.hp", 0, SEL_HP, 0);
    expectVal("win.win", 0, SEL_WIN, 1);
    expectVal("win.done", 0, SEL_DONE, 1);
    expectVal("win.score", 0, SEL_SCORE, 40);
    expectVal("win.fight", 0, SEL_FIGHT, 0);
    checkOutput();
    keyPress();
    expectVal("winKey.start", 0, SEL_START, 1);
    expectVal("winKey.done", 0, SEL_DONE, 0);
    expectVal("winKey.score", 0, SEL_SCORE, 40);
    expectVal("winKey.lives", 0, SEL_LIVES, 2);
    checkOutput();

    // New game down to one life, then a final kill and the fatal hit in the same cycle.
    keyPress();
    expectVal("game2.play", 0, SEL_PLAY, 1);
    expectVal("game2.lives", 0, SEL_LIVES, 3);
    expectVal("game2.score", 0, SEL_SCORE, 0);
    expectVal("game2.wave", 0, SEL_WAVE, 0);
    checkOutput();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 1);
      idle(1);
      respawnTicks(60);
    end
    expectVal("oneLife.lives", 0, SEL_LIVES, 1);
    expectVal("oneLife.play", 0, SEL_PLAY, 1);
    checkOutput();
    wlBase = wlCountA;
    applyStimulus(1'b1, 8'h00, 3'b111, 1'b0, 1'b0, 1'b0, 5);
    applyStimulus(1'b1, 8'h00, 3'b111, 1'b0, 1'b1, 1'b0, 1);
    idle(1);
    expectVal("lastHit.gameover", 0, SEL_GAMEOVER, 1);
    expectVal("lastHit.done", 0, SEL_DONE, 1);
    expectVal("lastHit.score", 0, SEL_SCORE, 18);
    expectVal("lastHit.lives", 0, SEL_LIVES, 0);
    expectVal("lastHit.wave", 0, SEL_WAVE, 0);
    expectVal("lastHit.play", 0, SEL_PLAY, 0);
    expectVal("lastHit.wlcnt", 0, SEL_WLCNT, wlBase);
    checkOutput();

    // Score saturation on the 4-bit instance, then reset in the middle of a boss fight.
    keyPress();
    keyPress();
    expectVal("game3.playB", 1, SEL_PLAY, 1);
    expectVal("game3.scoreB", 1, SEL_SCORE, 0);
    checkOutput();
    applyStimulus(1'b1, 8'h00, 3'b111, 1'b0, 1'b0, 1'b0, 6);
    applyStimulus(1'b1, 8'h00, 3'b011, 1'b0, 1'b0, 1'b0, 1);
    idle(1);
    expectVal("sat20.scoreB", 1, SEL_SCORE, 15);
    expectVal("sat20.scoreA", 0, SEL_SCORE, 20);
    expectVal("sat20.waveB", 1, SEL_WAVE, 1);
    checkOutput();
    applyStimulus(1'b1, 8'h00, 3'b111, 1'b0, 1'b0, 1'b0, 6);
    idle(1);
    expectVal("satBoss.logoA", 0, SEL_LOGO, 1);
    expectVal("satBoss.logoB", 1, SEL_LOGO, 1);
    expectVal("satBoss.scoreA", 0, SEL_SCORE, 38);
    expectVal("satBoss.scoreB", 1, SEL_SCORE, 15);
    checkOutput();
    keyPress();
    applyStimulus(1'b1, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 1);
    idle(1);
    expectVal("satFight.fightB", 1, SEL_FIGHT, 1);
    expectVal("satFight.hpB", 1, SEL_HP, 3);
    expectVal("satFight.scoreA", 0, SEL_SCORE, 39);
    expectVal("satFight.scoreB", 1, SEL_SCORE, 15);
    checkOutput();
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1);
    expectReset("midRstB", 1);
    expectReset("midRstA", 0);
    checkOutput();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
